// File: rtl/nmr_rx_pkg.sv
// Shared NMR receiver types and default widths.
package nmr_rx_pkg;

  // Default ADC / local-oscillator sample width (signed).
  localparam int DW    = 16;
  // Default accumulator width per channel.
  localparam int ACC_W = 48;
  // Width of the demodulated I/Q results.
  localparam int OUT_W = 32;
  // Width of the acquisition length and decimation controls.
  localparam int CNT_W = 16;

  // Acquisition controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // A decimation factor of zero behaves like one sample per output.
  function automatic logic [CNT_W-1:0] eff_dec(input logic [CNT_W-1:0] d);
    return (d == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : d;
  endfunction

endpackage : nmr_rx_pkg

// File: rtl/demod_mac.sv
// One demodulator channel: registered multiply, windowed accumulate, dump.
// Stage 1 registers the full-width product, stage 2 loads or adds it into
// the accumulator, stage 3 captures the scaled accumulator as the result.
module demod_mac #(
  parameter int DW    = nmr_rx_pkg::DW,
  parameter int ACC_W = nmr_rx_pkg::ACC_W,
  parameter int SHIFT = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [DW-1:0]                a_i,
  input  logic signed [DW-1:0]                b_i,
  input  logic                                mul_en_i,
  input  logic                                acc_en_i,
  input  logic                                acc_load_i,
  input  logic                                dump_en_i,
  output logic signed [nmr_rx_pkg::OUT_W-1:0] result_o
);
  import nmr_rx_pkg::*;

  localparam int PW = 2 * DW;

  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] res_q, res_d;

  // Next-state for product, accumulator and dumped result.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    res_d  = res_q;
    if (mul_en_i) begin
      // Both operands widened as signed first, so the product is exact.
      prod_d = PW'(a_i) * PW'(b_i);
    end
    if (acc_en_i) begin
      // A size cast of a signed value sign-extends the product.
      // The first sample of a window restarts the sum, so nothing is lost
      // between back-to-back windows.
      acc_d = acc_load_i ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
    end
    if (dump_en_i) begin
      res_d = OUT_W'(acc_q >>> SHIFT);
    end
  end

  // Pipeline registers, cleared by synchronous reset.
  // NOTE: state is updated only with non-blocking assignments in always_ff, so
  // every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
    end
  end

  assign result_o = res_q;

endmodule : demod_mac

// File: rtl/quad_demod.sv
// Quadrature demodulator: mixes the ADC stream with the cos/sin local
// oscillator, integrates over decimation windows and emits n_out I/Q pairs
// per acquisition. Each result appears 3 cycles after the edge accepting the
// last sample of its window.
module quad_demod #(
  parameter int DW    = nmr_rx_pkg::DW,
  parameter int ACC_W = nmr_rx_pkg::ACC_W,
  parameter int SHIFT = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic        [nmr_rx_pkg::CNT_W-1:0] n_out,
  input  logic        [nmr_rx_pkg::CNT_W-1:0] dec,
  input  logic signed [DW-1:0]                adc,
  input  logic                                adc_val,
  input  logic signed [DW-1:0]                sin_lo,
  input  logic signed [DW-1:0]                cos_lo,
  input  logic                                lo_val,
  output logic signed [nmr_rx_pkg::OUT_W-1:0] i_out,
  output logic signed [nmr_rx_pkg::OUT_W-1:0] q_out,
  output logic                                out_val,
  output logic                                busy,
  output logic                                done
);
  import nmr_rx_pkg::*;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [CNT_W-1:0] n_out_q, n_out_d;
  logic [CNT_W-1:0] dec_q, dec_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic accept;
  logic cfg_load;
  logic zero_req;
  logic win_first;
  logic win_last;
  logic acq_last;

  // Stage 0: operands and window flags captured at acceptance.
  logic signed [DW-1:0] adc_s0_q, cos_s0_q, sin_s0_q;
  logic s0_val_q, s0_first_q, s0_last_q, s0_final_q;
  // Stage 1: flags travelling alongside the registered products.
  logic s1_val_q, s1_first_q, s1_last_q, s1_final_q;
  // Stage 2: dump request alongside the updated accumulator.
  logic s2_dump_q, s2_final_q;
  // Stage 3: output strobes.
  logic out_val_q, done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && (n_out != '0)) state_d = ACQ;
      ACQ:     if (accept && acq_last)     state_d = FLUSH;
      FLUSH:   if (s2_final_q)             state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // State-derived control signals.
  always_comb begin
    busy     = (state_q != IDLE);
    accept   = (state_q == ACQ) && adc_val && lo_val;
    cfg_load = (state_q == IDLE) && start && (n_out != '0);
    zero_req = (state_q == IDLE) && start && (n_out == '0);
  end

  // Window position of the sample currently being offered.
  always_comb begin
    win_first = (win_cnt_q == '0);
    win_last  = (win_cnt_q == dec_q - ONE);
    acq_last  = win_last && (out_cnt_q == n_out_q - ONE);
  end

  // Configuration latch and sample/output counters.
  always_comb begin
    n_out_d   = n_out_q;
    dec_d     = dec_q;
    win_cnt_d = win_cnt_q;
    out_cnt_d = out_cnt_q;
    if (cfg_load) begin
      n_out_d   = n_out;
      dec_d     = eff_dec(dec);
      win_cnt_d = '0;
      out_cnt_d = '0;
    end else if (accept) begin
      if (win_last) begin
        win_cnt_d = '0;
        out_cnt_d = out_cnt_q + ONE;
      end else begin
        win_cnt_d = win_cnt_q + ONE;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_out_q   <= '0;
      dec_q     <= ONE;
      win_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      n_out_q   <= n_out_d;
      dec_q     <= dec_d;
      win_cnt_q <= win_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Stage 0 capture of the accepted sample and its window flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_s0_q   <= '0;
      cos_s0_q   <= '0;
      sin_s0_q   <= '0;
      s0_val_q   <= 1'b0;
      s0_first_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_final_q <= 1'b0;
    end else begin
      if (accept) begin
        adc_s0_q <= adc;
        cos_s0_q <= cos_lo;
        sin_s0_q <= sin_lo;
      end
      s0_val_q   <= accept;
      s0_first_q <= accept && win_first;
      s0_last_q  <= accept && win_last;
      s0_final_q <= accept && acq_last;
    end
  end

  // Flag pipeline following the data through stages 1..3.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_final_q <= 1'b0;
      s2_dump_q  <= 1'b0;
      s2_final_q <= 1'b0;
      out_val_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      s1_val_q   <= s0_val_q;
      s1_first_q <= s0_first_q;
      s1_last_q  <= s0_last_q;
      s1_final_q <= s0_final_q;
      s2_dump_q  <= s1_val_q && s1_last_q;
      s2_final_q <= s1_val_q && s1_final_q;
      out_val_q  <= s2_dump_q;
      done_q     <= s2_final_q || zero_req;
    end
  end

  demod_mac #(
    .DW   (DW),
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_mac_i (
    .clk       (clk),
    .rst       (rst),
    .a_i       (adc_s0_q),
    .b_i       (cos_s0_q),
    .mul_en_i  (s0_val_q),
    .acc_en_i  (s1_val_q),
    .acc_load_i(s1_first_q),
    .dump_en_i (s2_dump_q),
    .result_o  (i_out)
  );

  demod_mac #(
    .DW   (DW),
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_mac_q (
    .clk       (clk),
    .rst       (rst),
    .a_i       (adc_s0_q),
    .b_i       (sin_s0_q),
    .mul_en_i  (s0_val_q),
    .acc_en_i  (s1_val_q),
    .acc_load_i(s1_first_q),
    .dump_en_i (s2_dump_q),
    .result_o  (q_out)
  );

  assign out_val = out_val_q;
  assign done    = done_q;

endmodule : quad_demod

// File: tb/tb_quad_demod.sv
// Directed bench for quad_demod with a scoreboard of expected I/Q strobes.
module tb_quad_demod;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [15:0]          n_out;
  logic [15:0]          dec;
  logic signed [DW-1:0] adc;
  logic                 adc_val;
  logic signed [DW-1:0] sin_lo;
  logic signed [DW-1:0] cos_lo;
  logic                 lo_val;
  logic signed [31:0]   i_out;
  logic signed [31:0]   q_out;
  logic                 out_val;
  logic                 busy;
  logic                 done;

  quad_demod dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n_out  (n_out),
    .dec    (dec),
    .adc    (adc),
    .adc_val(adc_val),
    .sin_lo (sin_lo),
    .cos_lo (cos_lo),
    .lo_val (lo_val),
    .i_out  (i_out),
    .q_out  (q_out),
    .out_val(out_val),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned edge_n   = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int unsigned        edge_no;
    logic signed [31:0] i;
    logic signed [31:0] q;
    logic               dn;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned done_only_edge = 0;

  // Reference model state.
  bit     m_acq = 1'b0;
  int     m_win, m_out, m_dec, m_n;
  longint m_acc_i, m_acc_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (out_val === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_val", {31'b0, out_val}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_edge", edge_n, mon_e.edge_no);
        check("i_out", i_out, mon_e.i);
        check("q_out", q_out, mon_e.q);
        check("done_with_out", {31'b0, done}, {31'b0, mon_e.dn});
      end
    end else if (done === 1'b1) begin
      check("lone_done_edge", edge_n, done_only_edge);
    end
  end

  // One clock with the given sample inputs; the model tracks acceptance.
  task automatic step(input logic signed [15:0] a, input logic signed [15:0] c,
                      input logic signed [15:0] s, input logic av, input logic lv);
    bit     was_busy;
    longint pi, pq, t;
    exp_t   e;
    was_busy = m_acq || (sb.size() != 0);
    adc = a; cos_lo = c; sin_lo = s; adc_val = av; lo_val = lv;
    @(posedge clk);
    #1;
    if (m_acq && av && lv && rst !== 1'b1) begin
      pi = longint'(a) * longint'(c);
      pq = longint'(a) * longint'(s);
      if (m_win == 0) begin
        m_acc_i = pi; m_acc_q = pq;
      end else begin
        m_acc_i += pi; m_acc_q += pq;
      end
      if (m_win == m_dec - 1) begin
        t = m_acc_i >>> 16; e.i = t[31:0];
        t = m_acc_q >>> 16; e.q = t[31:0];
        e.edge_no = edge_n + 3;
        e.dn = (m_out + 1 == m_n);
        sb.push_back(e);
        m_win = 0;
        m_out++;
        if (m_out == m_n) m_acq = 1'b0;
      end else begin
        m_win++;
      end
    end
    if (start && !was_busy && rst !== 1'b1 && n_out != 0) begin
      m_acq = 1'b1; m_win = 0; m_out = 0; m_n = int'(n_out);
      m_dec = (dec == 0) ? 1 : int'(dec);
    end
  endtask

  task automatic do_start(input int n, input int d);
    n_out = 16'(n); dec = 16'(d); start = 1'b1;
    step(0, 0, 0, 1'b0, 1'b0);
    start = 1'b0;
  endtask

  // Idle cycles until every expected strobe has appeared, bounded.
  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step(0, 0, 0, 1'b0, 1'b0);
      k++;
    end
    step(0, 0, 0, 1'b0, 1'b0);
    check("drain_empty", sb.size(), 32'd0);
    check("idle_after_drain", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_out = '0; dec = '0;
    adc = '0; cos_lo = '0; sin_lo = '0; adc_val = 1'b0; lo_val = 1'b0;
    step(0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 1'b0, 1'b0);
    check("rst_i_out", i_out, 32'd0);
    check("rst_q_out", q_out, 32'd0);
    check("rst_out_val", {31'b0, out_val}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    step(0, 0, 0, 1'b0, 1'b0);

    // Scenario 1: dec=1, four back-to-back results of 250 / 0.
    do_start(4, 1);
    check("s1_busy", {31'b0, busy}, 32'd1);
    repeat (4) step(1000, 16384, 0, 1'b1, 1'b1);
    drain(12);

    // Scenario 2: dec=4, two results of 2000 / -1000; start mid-ACQ ignored.
    do_start(2, 4);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        start = 1'b1; n_out = 16'd7; dec = 16'd1;
      end
      step(-2000, -16384, 8192, 1'b1, 1'b1);
      start = 1'b0;
    end
    drain(12);

    // Scenario 3: dec=3, toggling adc_val and a 5-cycle lo_val gap.
    do_start(1, 3);
    for (int k = 0; k < 14; k++)
      step(1000, 16384, 0, (k % 2) == 0, !(k >= 2 && k < 7));
    drain(12);

    // Scenario 4: n_out=0 pulses done alone on the next cycle.
    do_start(0, 5);
    done_only_edge = edge_n;
    check("zero_done", {31'b0, done}, 32'd1);
    check("zero_no_out_val", {31'b0, out_val}, 32'd0);
    check("zero_busy", {31'b0, busy}, 32'd0);
    step(0, 0, 0, 1'b0, 1'b0);
    check("zero_done_pulse", {31'b0, done}, 32'd0);

    // dec=0 behaves as dec=1.
    do_start(2, 0);
    step(1000, 16384, -16384, 1'b1, 1'b1);
    step(1000, 16384, -16384, 1'b1, 1'b1);
    drain(12);

    // Scenario 5: full-scale products over the longest window.
    do_start(1, 65535);
    repeat (65535) step(-32768, -32768, 0, 1'b1, 1'b1);
    drain(12);

    // Scenario 6: reset mid-window discards everything.
    do_start(2, 4);
    step(1000, 16384, 8192, 1'b1, 1'b1);
    step(1000, 16384, 8192, 1'b1, 1'b1);
    rst = 1'b1;
    step(0, 0, 0, 1'b0, 1'b0);
    m_acq = 1'b0;
    check("mid_rst_i_out", i_out, 32'd0);
    check("mid_rst_q_out", q_out, 32'd0);
    check("mid_rst_out_val", {31'b0, out_val}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    repeat (5) step(0, 0, 0, 1'b0, 1'b0);
    do_start(1, 1);
    step(-2000, -16384, 8192, 1'b1, 1'b1);
    drain(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_quad_demod

// File: doc/quad_demod.md
QUAD_DEMOD -- requirements
Module: quad_demod

Interface
REQ-001 SHALL have parameter DW, default 16, meaning ADC and local-oscillator sample width (signed).
REQ-002 SHALL have parameter ACC_W, default 48, meaning accumulator width per channel.
REQ-003 SHALL have parameter SHIFT, default 16, meaning arithmetic right shift applied to the accumulator at output.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: pulse that begins an acquisition.
REQ-007 SHALL have port n_out, input, 16 bits: number of I/Q output pairs per acquisition, latched at start.
REQ-008 SHALL have port dec, input, 16 bits: accepted samples per output, latched at start; value 0 is treated as 1.
REQ-009 SHALL have port adc, input, DW bits: signed receiver sample.
REQ-010 SHALL have port adc_val, input, 1 bit: adc is valid.
REQ-011 SHALL have ports sin_lo and cos_lo, input, DW bits each: signed quadrature local oscillator from the DDS array.
REQ-012 SHALL have port lo_val, input, 1 bit: sin_lo and cos_lo are valid.
REQ-013 SHALL have ports i_out and q_out, output, 32 bits each: signed demodulated result.
REQ-014 SHALL have port out_val, output, 1 bit: one-cycle strobe marking a valid i_out/q_out pair.
REQ-015 SHALL have port busy, output, 1 bit: high outside IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at the end of an acquisition.

Function
REQ-017 SHALL accept a sample on a cycle only when state is ACQ and adc_val and lo_val are both 1; on all other cycles the sample is ignored and no counter advances.
REQ-018 SHALL register the products adc*cos_lo (I) and adc*sin_lo (Q) as full 2*DW-bit signed values one cycle after acceptance (pipeline stage 1).
REQ-019 SHALL sign-extend each product and add it to its ACC_W accumulator in stage 2.
REQ-020 SHALL load the accumulator with the incoming product, not add to it, on the first sample of each decimation window, so that no sample is lost between windows.
REQ-021 SHALL present i_out/q_out as the low 32 bits of (accumulator >>> SHIFT), together with out_val=1, exactly 3 cycles after the edge that accepts the dec-th sample of a window.
REQ-022 SHALL hold i_out/q_out at their last values between strobes.
REQ-023 SHALL implement the states IDLE, ACQ and FLUSH.
REQ-024 In IDLE, start=1 with n_out>0 SHALL latch n_out and dec, clear the counters and enter ACQ.
REQ-025 In IDLE, start=1 with n_out=0 SHALL leave the block in IDLE and SHALL pulse done on the next cycle, with no out_val.
REQ-026 SHALL move from ACQ to FLUSH on the edge that accepts sample number n_out*dec.
REQ-027 SHALL move from FLUSH to IDLE when the final out_val is issued, and SHALL assert done in the same cycle as that final out_val.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL not overflow the accumulator for any inputs when dec=65535 and DW=16.

Reset
REQ-030 On rst=1, the block SHALL on the next edge enter IDLE and clear the pipeline, accumulators and counters.
REQ-031 After reset, i_out, q_out, out_val, busy and done SHALL all be 0.
REQ-032 Reset asserted mid-acquisition SHALL discard the partial window without issuing out_val or done.

Structure
REQ-033 SHALL take DW, ACC_W, the state enum and the output width of 32 from the shared package nmr_rx_pkg.
REQ-034 SHALL implement each channel's multiply-accumulate-dump in a sub-module demod_mac, instantiated twice (I and Q).

Verification
REQ-035 Scenario 1: dec=1, n_out=4, adc=1000, cos_lo=16384, sin_lo=0, valids held high -> four consecutive out_val with i_out=250, q_out=0; done asserted with the 4th out_val.
REQ-036 Scenario 2: dec=4, n_out=2, adc=-2000, cos_lo=-16384, sin_lo=8192 -> two strobes, each with i_out=2000, q_out=-1000.
REQ-037 Scenario 3: dec=3, adc_val toggling each cycle, lo_val low for 5 cycles mid-window -> out_val issued only 3 cycles after the 3rd accepted sample, and values match scenario 1 scaling.
REQ-038 Scenario 4: start with n_out=0 -> done on the next cycle with no out_val; start pulsed during ACQ -> no effect on the output count.
REQ-039 Scenario 5: dec=65535, adc=-32768, cos_lo=-32768 -> i_out=1073725440 with no wrap.
REQ-040 Scenario 6: rst during ACQ -> the next cycle shows all outputs 0 and busy=0; a following start with dec=1, n_out=1 produces a correct single result.
